// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: merges stall requests and runs the exception/ERET drain-flush-redirect FSM.
// Define PIPE_HAZARD_PERF_EN to add the perf_stall_cycles / perf_flush_count counters.
module pipeline_hazard_ctrl #(
    parameter int STAGE_NUM  = 5,
    parameter int FLUSH_HOLD = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAGE_NUM-1:0]  stall_req,
    input  logic                  exc_req,
    input  logic [ADDR_WIDTH-1:0] exc_target,
    input  logic                  eret_req,
    input  logic [ADDR_WIDTH-1:0] epc_in,
    input  logic                  mem_busy,
    output logic [STAGE_NUM-1:0]  stall_out,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
`ifdef PIPE_HAZARD_PERF_EN
    output logic                  ctrl_busy,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles,
    output logic [PERF_WIDTH-1:0] perf_flush_count
`else
    output logic                  ctrl_busy
`endif
);

    localparam int CNT_W = 4;

    if (FLUSH_HOLD < 1 || FLUSH_HOLD > 15 || PERF_WIDTH < 1) begin : g_bad_param
        $error("pipeline_hazard_ctrl: FLUSH_HOLD must be 1..15 and PERF_WIDTH >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    flush_q, flush_d;
    logic                    redirect_valid_q, redirect_valid_d;
    logic [ADDR_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
    logic                    ctrl_busy_q, ctrl_busy_d;
    logic [STAGE_NUM-1:0]    stall_merge;

    // A stall in stage j must freeze every earlier stage, so sweep from WB back to IF.
    always_comb begin
        logic acc;
        acc         = 1'b0;
        stall_merge = '0;
        for (int i = STAGE_NUM - 1; i >= 0; i--) begin
            acc            = acc | stall_req[i];
            stall_merge[i] = acc;
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:  stall_out = stall_merge;
            S_DRAIN: stall_out = '1;
            default: stall_out = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (exc_req) begin
                    redirect_pc_d = exc_target;
                    state_d       = mem_busy ? S_DRAIN : S_FLUSH;
                end else if (eret_req) begin
                    redirect_pc_d = epc_in;
                    state_d       = mem_busy ? S_DRAIN : S_FLUSH;
                end
            end
            S_DRAIN: begin
                if (!mem_busy) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (state_d == S_FLUSH && state_q != S_FLUSH) begin
            cnt_d = CNT_W'(FLUSH_HOLD - 1);
        end

        // Outputs are registered from the next state so they change on the entering edge.
        flush_d          = (state_d == S_FLUSH);
        redirect_valid_d = (state_d == S_REDIRECT);
        ctrl_busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ctrl_busy_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            ctrl_busy_q      <= ctrl_busy_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign ctrl_busy      = ctrl_busy_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_WIDTH-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_WIDTH-1:0] perf_flush_q, perf_flush_d;

    // Both counters wrap freely; no saturation.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_out[0]) begin
            perf_stall_d = perf_stall_q + PERF_WIDTH'(1);
        end
        if (state_d == S_FLUSH && state_q != S_FLUSH) begin
            perf_flush_d = perf_flush_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (FLUSH_HOLD=1 and 3) on shared stimulus, checked against a phase model.
module tb_pipeline_hazard_ctrl;

    localparam int SN = 5;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [SN-1:0] stall_req;
    logic          exc_req, eret_req, mem_busy;
    logic [AW-1:0] exc_target, epc_in;

    logic [SN-1:0] so1, so3;
    logic          fl1, fl3, rv1, rv3, cb1, cb3;
    logic [AW-1:0] pc1, pc3;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0]   ps1, pf1, ps3, pf3;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.STAGE_NUM(SN), .FLUSH_HOLD(1), .ADDR_WIDTH(AW), .PERF_WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .exc_req(exc_req), .exc_target(exc_target),
        .eret_req(eret_req), .epc_in(epc_in), .mem_busy(mem_busy), .stall_out(so1), .flush(fl1),
        .redirect_valid(rv1), .redirect_pc(pc1),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cycles(ps1), .perf_flush_count(pf1),
`endif
        .ctrl_busy(cb1)
    );

    pipeline_hazard_ctrl #(.STAGE_NUM(SN), .FLUSH_HOLD(3), .ADDR_WIDTH(AW), .PERF_WIDTH(32)) dut3 (
        .clk(clk), .rst(rst), .stall_req(stall_req), .exc_req(exc_req), .exc_target(exc_target),
        .eret_req(eret_req), .epc_in(epc_in), .mem_busy(mem_busy), .stall_out(so3), .flush(fl3),
        .redirect_valid(rv3), .redirect_pc(pc3),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cycles(ps3), .perf_flush_count(pf3),
`endif
        .ctrl_busy(cb3)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model per instance: busy/draining flags plus cycles remaining until idle once draining ends
    // (rem > 1 means flushing, rem == 1 means the redirect cycle).
    int          hold    [2] = '{1, 3};
    bit          m_busy  [2] = '{0, 0};
    bit          m_drain [2] = '{0, 0};
    int          m_rem   [2] = '{0, 0};
    logic [31:0] m_pc    [2] = '{0, 0};
    logic [31:0] m_ps    [2] = '{0, 0};
    logic [31:0] m_pf    [2] = '{0, 0};

    function automatic logic [SN-1:0] merge(input logic [SN-1:0] r);
        logic [SN-1:0] e;
        for (int i = 0; i < SN; i++) e[i] = ((r >> i) != 0);
        return e;
    endfunction

    function automatic logic [SN-1:0] exp_so(input int k);
        if (!m_busy[k]) return merge(stall_req);
        if (m_drain[k]) return '1;
        return '0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0; m_drain[k] <= 1'b0; m_rem[k] <= 0; m_pc[k] <= '0;
                m_ps[k] <= '0; m_pf[k] <= '0;
            end else begin
                if (exp_so(k)[0]) m_ps[k] <= m_ps[k] + 1;
                if (!m_busy[k]) begin
                    if (exc_req || eret_req) begin
                        m_pc[k]    <= exc_req ? exc_target : epc_in;
                        m_busy[k]  <= 1'b1;
                        m_drain[k] <= mem_busy;
                        m_rem[k]   <= hold[k] + 1;
                        if (!mem_busy) m_pf[k] <= m_pf[k] + 1;
                    end
                end else if (m_drain[k]) begin
                    if (!mem_busy) begin
                        m_drain[k] <= 1'b0;
                        m_pf[k]    <= m_pf[k] + 1;
                    end
                end else begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) m_busy[k] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int h, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (hold=%0d) got=%h want=%h", nm, h, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic [SN-1:0] so, input logic fl, input logic rv,
                       input logic [31:0] pc, input logic cb);
        chk("stall_out", hold[k], 32'(so), 32'(exp_so(k)));
        chk("flush", hold[k], 32'(fl), 32'(m_busy[k] && !m_drain[k] && m_rem[k] > 1));
        chk("redirect_valid", hold[k], 32'(rv), 32'(m_busy[k] && !m_drain[k] && m_rem[k] == 1));
        chk("redirect_pc", hold[k], pc, m_pc[k]);
        chk("ctrl_busy", hold[k], 32'(cb), 32'(m_busy[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, so1, fl1, rv1, pc1, cb1);
            cmp(1, so3, fl3, rv3, pc3, cb3);
`ifdef PIPE_HAZARD_PERF_EN
            chk("perf_stall_cycles", 1, ps1, m_ps[0]);
            chk("perf_flush_count", 1, pf1, m_pf[0]);
            chk("perf_stall_cycles", 3, ps3, m_ps[1]);
            chk("perf_flush_count", 3, pf3, m_pf[1]);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nf, nr;
        rst = 1'b1; stall_req = '0; exc_req = 1'b0; eret_req = 1'b0; mem_busy = 1'b0;
        exc_target = '0; epc_in = '0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst stall_out", 1, 32'(so1), 32'h0);
        chk("rst flush", 1, 32'(fl1), 32'h0);
        chk("rst ctrl_busy", 1, 32'(cb1), 32'h0);
        chk("rst redirect_pc", 1, pc1, 32'h0);
        tick();
        rst = 1'b0;

        // Stall merge in IDLE
        stall_req = 5'b01000; @(negedge clk); chk("merge 01000", 1, 32'(so1), 32'h0F);
        tick(); stall_req = 5'b00001; @(negedge clk); chk("merge 00001", 1, 32'(so1), 32'h01);
        tick(); stall_req = 5'b00100; @(negedge clk); chk("merge 00100", 1, 32'(so1), 32'h07);
        tick(); stall_req = 5'b00000; @(negedge clk); chk("merge 00000", 1, 32'(so1), 32'h00);

        // Exception, no drain
        tick(); exc_req = 1'b1; exc_target = 32'hBFC00380;
        tick(); exc_req = 1'b0;
        @(negedge clk); chk("exc N+1 flush", 1, 32'(fl1), 32'h1); chk("exc N+1 rv", 1, 32'(rv1), 32'h0);
        @(negedge clk); chk("exc N+2 rv", 1, 32'(rv1), 32'h1); chk("exc N+2 pc", 1, pc1, 32'hBFC00380);
        chk("exc N+2 flush", 1, 32'(fl1), 32'h0);
        @(negedge clk); chk("exc N+3 busy", 1, 32'(cb1), 32'h0);
        repeat (4) tick();

        // Exception with drain; second request during DRAIN must be ignored
        exc_req = 1'b1; mem_busy = 1'b1; exc_target = 32'hBFC00380;
        tick(); exc_req = 1'b0;
        @(negedge clk); chk("drain stall_out", 1, 32'(so1), 32'h1F);
        tick(); exc_req = 1'b1; exc_target = 32'h12345678;
        tick(); exc_req = 1'b0; exc_target = 32'hBFC00380;
        tick(); tick(); mem_busy = 1'b0;
        @(negedge clk); chk("drain last stall_out", 1, 32'(so1), 32'h1F);
        tick();
        @(negedge clk); chk("post-drain flush", 1, 32'(fl1), 32'h1); chk("flush stall_out", 1, 32'(so1), 32'h0);
        tick();
        @(negedge clk); chk("post-drain rv", 1, 32'(rv1), 32'h1); chk("post-drain pc", 1, pc1, 32'hBFC00380);
        repeat (6) tick();

        // Simultaneous exc+eret, then eret alone
        exc_req = 1'b1; eret_req = 1'b1; epc_in = 32'h80001000; exc_target = 32'hBFC00380;
        tick(); exc_req = 1'b0; eret_req = 1'b0;
        repeat (8) tick();
        @(negedge clk); chk("both pc", 1, pc1, 32'hBFC00380); chk("both pc", 3, pc3, 32'hBFC00380);
        tick(); eret_req = 1'b1;
        tick(); eret_req = 1'b0;
        repeat (8) tick();
        @(negedge clk); chk("eret pc", 1, pc1, 32'h80001000); chk("eret pc", 3, pc3, 32'h80001000);

        // FLUSH_HOLD=3: flush width and single redirect
        tick(); exc_req = 1'b1; exc_target = 32'hBFC00380;
        tick(); exc_req = 1'b0;
        nf = 0; nr = 0;
        repeat (8) begin @(negedge clk); nf += int'(fl3); nr += int'(rv3); end
        chk("hold3 flush cycles", 3, 32'(nf), 32'd3);
        chk("hold3 redirect cycles", 3, 32'(nr), 32'd1);

        // Reset during the 2nd flush cycle of the FLUSH_HOLD=3 instance
        tick(); exc_req = 1'b1; exc_target = 32'hAAAA0000;
        tick(); exc_req = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst-mid flush", 3, 32'(fl3), 32'h0);
        chk("rst-mid rv", 3, 32'(rv3), 32'h0);
        chk("rst-mid busy", 3, 32'(cb3), 32'h0);
        chk("rst-mid pc", 3, pc3, 32'h0);
        nr = 0;
        repeat (6) begin @(negedge clk); nr += int'(rv3); end
        chk("rst-mid no redirect", 3, 32'(nr), 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
